cv32e40p_wb_stage: RTL and testbench

Write-back stage directly downstream of the execute stage. It accepts one retiring instruction per handshake, collects the LSU read response and aligns and sign-extends load data. It merges the two halves of a misaligned load and drives the load write port of the register file. It also retires the custom countermeasure flag that travels alongside each instruction.

---
 rtl/cv32e40p_pkg.sv | 19 +
 rtl/cv32e40p_load_align.sv | 54 +++++
 rtl/cv32e40p_wb_stage.sv | 108 ++++++++++
 tb/tb_cv32e40p_wb_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_pkg.sv
// Shared types for the cv32e40p write-back stage: FSM states and load size/extension encodings.
package cv32e40p_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_RESP   = 2'd1,
    WAIT_SECOND = 2'd2
  } wb_state_e;

  // Load size; 2'b11 is also treated as a byte.
  localparam logic [1:0] WB_WORD = 2'b00;
  localparam logic [1:0] WB_HALF = 2'b01;
  localparam logic [1:0] WB_BYTE = 2'b10;

  localparam logic [1:0] WB_EXT_ZERO = 2'b00;
  localparam logic [1:0] WB_EXT_SIGN = 2'b01;
  localparam logic [1:0] WB_EXT_ONE  = 2'b10;

endpackage

// File: rtl/cv32e40p_load_align.sv
// Combinational load alignment: rotate or merge the response words, then zero/sign/one-extend the field.
module cv32e40p_load_align
  import cv32e40p_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] residual,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        data_type,
  input  logic [1:0]        offset,
  input  logic [1:0]        sign_ext,
  input  logic              misaligned,
  output logic [DATA_W-1:0] wdata
);

  function automatic logic [DATA_W-1:0] ext_half(input logic [15:0] h, input logic [1:0] mode);
    logic signed [15:0] hs;
    hs = h;
    case (mode)
      WB_EXT_SIGN: ext_half = DATA_W'(hs);
      WB_EXT_ONE:  ext_half = {{(DATA_W-16){1'b1}}, h};
      default:     ext_half = {{(DATA_W-16){1'b0}}, h};
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] b, input logic [1:0] mode);
    logic signed [7:0] bs;
    bs = b;
    case (mode)
      WB_EXT_SIGN: ext_byte = DATA_W'(bs);
      WB_EXT_ONE:  ext_byte = {{(DATA_W-8){1'b1}}, b};
      default:     ext_byte = {{(DATA_W-8){1'b0}}, b};
    endcase
  endfunction

  // A single right shift covers both the aligned rotate ({rdata,rdata}) and the
  // two-word merge ({second,residual}); the wanted field always lands at bit 0.
  logic [2*DATA_W-1:0] src;
  logic [2*DATA_W-1:0] src_sh;
  logic [DATA_W-1:0]   shifted;

  assign src     = misaligned ? {rdata, residual} : {rdata, rdata};
  assign src_sh  = src >> {offset, 3'b000};
  assign shifted = src_sh[DATA_W-1:0];

  always_comb begin
    case (data_type)
      WB_WORD: wdata = shifted;
      WB_HALF: wdata = ext_half(shifted[15:0], sign_ext);
      default: wdata = ext_byte(shifted[7:0], sign_ext);
    endcase
  end

endmodule

// File: rtl/cv32e40p_wb_stage.sv
// Write-back stage: collects LSU load responses, aligns/merges them and retires the custom lui flag.
// Optional CV32E40P_WB_CSTM_CHECK_EN adds the registered cstm_alert_o countermeasure check.
module cv32e40p_wb_stage
  import cv32e40p_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid_i,
  output logic              wb_ready_o,
  input  logic              lsu_load_i,
  input  logic [ADDR_W-1:0] regfile_waddr_i,
  input  logic [1:0]        data_type_i,
  input  logic [1:0]        data_sign_ext_i,
  input  logic [1:0]        data_reg_offset_i,
  input  logic              data_misaligned_i,
  input  logic              lsu_rvalid_i,
  input  logic [DATA_W-1:0] lsu_rdata_i,
  input  logic              lsu_err_i,
  input  logic              cstm_lui_executed_i,
  output logic              regfile_we_o,
  output logic [ADDR_W-1:0] regfile_waddr_o,
  output logic [DATA_W-1:0] regfile_wdata_o,
  output logic              load_err_o,
  output logic              cstm_lui_executed_o
`ifdef CV32E40P_WB_CSTM_CHECK_EN
  ,
  output logic              cstm_alert_o
`endif
);

  wb_state_e         state, state_n;
  logic [ADDR_W-1:0] cap_waddr;
  logic [1:0]        cap_type, cap_sext, cap_off;
  logic              cap_mis, cap_cstm;
  logic              nl_vld_q;
  logic [DATA_W-1:0] residual;
  logic [DATA_W-1:0] align_data;
  logic              accept, resp_done, split;

  // Error on the first half of a split load also terminates the transaction.
  assign resp_done = lsu_rvalid_i & ((state == WAIT_SECOND) |
                                     ((state == WAIT_RESP) & (~cap_mis | lsu_err_i)));
  assign split     = lsu_rvalid_i & (state == WAIT_RESP) & cap_mis & ~lsu_err_i;
  assign wb_ready_o = (state == IDLE) | resp_done;
  assign accept     = ex_valid_i & wb_ready_o;

  always_comb begin
    state_n = state;
    if (accept)         state_n = lsu_load_i ? WAIT_RESP : IDLE;
    else if (resp_done) state_n = IDLE;
    else if (split)     state_n = WAIT_SECOND;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cap_waddr <= '0;
      cap_type  <= '0;
      cap_sext  <= '0;
      cap_off   <= '0;
      cap_mis   <= 1'b0;
      cap_cstm  <= 1'b0;
      nl_vld_q  <= 1'b0;
      residual  <= '0;
    end else begin
      state    <= state_n;
      nl_vld_q <= accept & ~lsu_load_i;
      if (accept) begin
        cap_waddr <= regfile_waddr_i;
        cap_type  <= data_type_i;
        cap_sext  <= data_sign_ext_i;
        cap_off   <= data_reg_offset_i;
        cap_mis   <= data_misaligned_i;
        cap_cstm  <= cstm_lui_executed_i;
      end
      if (split) residual <= lsu_rdata_i;
    end
  end

  cv32e40p_load_align #(.DATA_W(DATA_W)) u_load_align (
    .residual   (residual),
    .rdata      (lsu_rdata_i),
    .data_type  (cap_type),
    .offset     (cap_off),
    .sign_ext   (cap_sext),
    .misaligned (state == WAIT_SECOND),
    .wdata      (align_data)
  );

  assign regfile_we_o        = resp_done & ~lsu_err_i;
  assign regfile_waddr_o     = regfile_we_o ? cap_waddr : '0;
  assign regfile_wdata_o     = regfile_we_o ? align_data : '0;
  assign load_err_o          = resp_done & lsu_err_i;
  assign cstm_lui_executed_o = (regfile_we_o | nl_vld_q) & cap_cstm;

`ifdef CV32E40P_WB_CSTM_CHECK_EN
  logic alert_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alert_q <= 1'b0;
    else        alert_q <= (load_err_o & cap_cstm) | (accept & lsu_load_i & cstm_lui_executed_i);
  end
  assign cstm_alert_o = alert_q;
`endif

endmodule

// File: tb/tb_cv32e40p_wb_stage.sv
// Scoreboard bench for cv32e40p_wb_stage: directed loads push expected retire events, a monitor checks them.
module tb_cv32e40p_wb_stage;
  import cv32e40p_pkg::*;

  logic        clk, rst_n;
  logic        ex_valid_i, wb_ready_o, lsu_load_i;
  logic [5:0]  regfile_waddr_i;
  logic [1:0]  data_type_i, data_sign_ext_i, data_reg_offset_i;
  logic        data_misaligned_i, lsu_rvalid_i, lsu_err_i, cstm_lui_executed_i;
  logic [31:0] lsu_rdata_i;
  logic        regfile_we_o, load_err_o, cstm_lui_executed_o;
  logic [5:0]  regfile_waddr_o;
  logic [31:0] regfile_wdata_o;
`ifdef CV32E40P_WB_CSTM_CHECK_EN
  logic        cstm_alert_o;
`endif

  cv32e40p_wb_stage #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .ex_valid_i          (ex_valid_i),
    .wb_ready_o          (wb_ready_o),
    .lsu_load_i          (lsu_load_i),
    .regfile_waddr_i     (regfile_waddr_i),
    .data_type_i         (data_type_i),
    .data_sign_ext_i     (data_sign_ext_i),
    .data_reg_offset_i   (data_reg_offset_i),
    .data_misaligned_i   (data_misaligned_i),
    .lsu_rvalid_i        (lsu_rvalid_i),
    .lsu_rdata_i         (lsu_rdata_i),
    .lsu_err_i           (lsu_err_i),
    .cstm_lui_executed_i (cstm_lui_executed_i),
    .regfile_we_o        (regfile_we_o),
    .regfile_waddr_o     (regfile_waddr_o),
    .regfile_wdata_o     (regfile_wdata_o),
    .load_err_o          (load_err_o),
    .cstm_lui_executed_o (cstm_lui_executed_o)
`ifdef CV32E40P_WB_CSTM_CHECK_EN
    ,
    .cstm_alert_o        (cstm_alert_o)
`endif
  );

  typedef struct {
    logic        we;
    logic [5:0]  waddr;
    logic [31:0] wdata;
    logic        err;
    logic        cstm;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    ex_valid_i   = 1'b0;
    lsu_rvalid_i = 1'b0;
    lsu_err_i    = 1'b0;
  endtask

  task automatic acc(input logic ld, input logic [5:0] wa, input logic [1:0] ty,
                     input logic [1:0] se, input logic [1:0] off, input logic mis,
                     input logic cstm);
    ex_valid_i          = 1'b1;
    lsu_load_i          = ld;
    regfile_waddr_i     = wa;
    data_type_i         = ty;
    data_sign_ext_i     = se;
    data_reg_offset_i   = off;
    data_misaligned_i   = mis;
    cstm_lui_executed_i = cstm;
  endtask

  task automatic resp(input logic [31:0] d, input logic e);
    lsu_rvalid_i = 1'b1;
    lsu_rdata_i  = d;
    lsu_err_i    = e;
  endtask

  task automatic push(input logic we, input logic [5:0] wa, input logic [31:0] wd,
                      input logic err, input logic cstm);
    exp_t e;
    e.we = we; e.waddr = wa; e.wdata = wd; e.err = err; e.cstm = cstm;
    q.push_back(e);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every visible retire event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && (regfile_we_o || load_err_o || cstm_lui_executed_o)) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_retire: got we=%0b waddr=%0d wdata=0x%08h err=%0b cstm=%0b, expected none",
                 regfile_we_o, regfile_waddr_o, regfile_wdata_o, load_err_o, cstm_lui_executed_o);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (regfile_we_o !== e.we || load_err_o !== e.err || cstm_lui_executed_o !== e.cstm ||
            (e.we && (regfile_waddr_o !== e.waddr || regfile_wdata_o !== e.wdata))) begin
          n_err++;
          $display("FAIL retire: got we=%0b waddr=%0d wdata=0x%08h err=%0b cstm=%0b, expected we=%0b waddr=%0d wdata=0x%08h err=%0b cstm=%0b",
                   regfile_we_o, regfile_waddr_o, regfile_wdata_o, load_err_o, cstm_lui_executed_o,
                   e.we, e.waddr, e.wdata, e.err, e.cstm);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    quiet();
    lsu_load_i = 1'b0; regfile_waddr_i = '0; data_type_i = '0; data_sign_ext_i = '0;
    data_reg_offset_i = '0; data_misaligned_i = 1'b0; cstm_lui_executed_i = 1'b0;
    lsu_rdata_i = '0;

    repeat (2) @(posedge clk);
    #3;
    chk1("rst_ready", wb_ready_o, 1'b1);
    chk1("rst_we", regfile_we_o, 1'b0);
    chk1("rst_err", load_err_o, 1'b0);
    chk1("rst_cstm", cstm_lui_executed_o, 1'b0);
    tick();
    rst_n = 1'b1;

    // Aligned word
    acc(1'b1, 6'd5, WB_WORD, WB_EXT_ZERO, 2'd0, 1'b0, 1'b0);
    tick(); quiet();
    resp(32'hDEADBEEF, 1'b0); push(1'b1, 6'd5, 32'hDEADBEEF, 1'b0, 1'b0);
    #2 chk1("word_ready", wb_ready_o, 1'b1);
    tick(); quiet();

    // Signed byte then zero-extended byte at offset 2
    acc(1'b1, 6'd7, WB_BYTE, WB_EXT_SIGN, 2'd2, 1'b0, 1'b1);
    tick(); quiet();
    resp(32'h0080_0000, 1'b0); push(1'b1, 6'd7, 32'hFFFFFF80, 1'b0, 1'b1);
    tick(); quiet();
    acc(1'b1, 6'd8, WB_BYTE, WB_EXT_ZERO, 2'd2, 1'b0, 1'b0);
    tick(); quiet();
    resp(32'h0080_0000, 1'b0); push(1'b1, 6'd8, 32'h00000080, 1'b0, 1'b0);
    tick(); quiet();

    // Misaligned word, offset 1
    acc(1'b1, 6'd9, WB_WORD, WB_EXT_ZERO, 2'd1, 1'b1, 1'b0);
    tick(); quiet();
    resp(32'h44332211, 1'b0);
    #2 chk1("mis_first_ready", wb_ready_o, 1'b0);
    chk1("mis_first_we", regfile_we_o, 1'b0);
    tick(); quiet();
    resp(32'h88776655, 1'b0); push(1'b1, 6'd9, 32'h55443322, 1'b0, 1'b0);
    tick(); quiet();

    // Misaligned load, error on first half; late second rvalid ignored
    acc(1'b1, 6'd10, WB_WORD, WB_EXT_ZERO, 2'd2, 1'b1, 1'b1);
    tick(); quiet();
    resp(32'hCAFEF00D, 1'b1); push(1'b0, 6'd0, 32'h0, 1'b1, 1'b0);
    #2 chk1("err_ready", wb_ready_o, 1'b1);
    tick(); quiet();
    resp(32'h12345678, 1'b0);
    #2 chk1("err_second_ignored", regfile_we_o, 1'b0);
    tick(); quiet();

    // Back-to-back: B accepted in A's final-response cycle
    acc(1'b1, 6'd11, WB_HALF, WB_EXT_SIGN, 2'd0, 1'b0, 1'b0);
    tick(); quiet();
    resp(32'h00008001, 1'b0); push(1'b1, 6'd11, 32'hFFFF8001, 1'b0, 1'b0);
    acc(1'b1, 6'd12, WB_BYTE, WB_EXT_ZERO, 2'd3, 1'b0, 1'b1);
    #2 chk1("b2b_ready", wb_ready_o, 1'b1);
    tick(); quiet();
    resp(32'hAB000000, 1'b0); push(1'b1, 6'd12, 32'h000000AB, 1'b0, 1'b1);
    tick(); quiet();

    // Non-load retires its flag the cycle after accept
    acc(1'b0, 6'd20, WB_WORD, WB_EXT_ZERO, 2'd0, 1'b0, 1'b1);
    push(1'b0, 6'd0, 32'h0, 1'b0, 1'b1);
    tick(); quiet();
    #2 chk1("nonload_ready", wb_ready_o, 1'b1);
    tick();

    // Misaligned half at offset 3, one-extended
    acc(1'b1, 6'd14, WB_HALF, WB_EXT_ONE, 2'd3, 1'b1, 1'b0);
    tick(); quiet();
    resp(32'h12345678, 1'b0);
    tick(); quiet();
    resp(32'hAABBCC56, 1'b0); push(1'b1, 6'd14, 32'hFFFF5612, 1'b0, 1'b0);
    tick(); quiet();

    // Aligned word with offset 2 rotates
    acc(1'b1, 6'd15, WB_WORD, WB_EXT_ZERO, 2'd2, 1'b0, 1'b0);
    tick(); quiet();
    resp(32'h11223344, 1'b0); push(1'b1, 6'd15, 32'h33441122, 1'b0, 1'b0);
    tick(); quiet();

    // Reset while waiting for the second half
    acc(1'b1, 6'd13, WB_WORD, WB_EXT_ZERO, 2'd1, 1'b1, 1'b1);
    tick(); quiet();
    resp(32'h44332211, 1'b0);
    tick(); quiet();
    #1 rst_n = 1'b0;
    #1;
    chk1("rst_mid_ready", wb_ready_o, 1'b1);
    chk1("rst_mid_we", regfile_we_o, 1'b0);
    chk1("rst_mid_cstm", cstm_lui_executed_o, 1'b0);
    tick();
    rst_n = 1'b1;
    resp(32'h88776655, 1'b0);
    #2 chk1("post_rst_we", regfile_we_o, 1'b0);
    chk1("post_rst_ready", wb_ready_o, 1'b1);
    tick(); quiet();
    repeat (2) tick();

    chk32("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
